// File: rtl/instruction_encoder.sv
// RV32I field packer: turns decoded fields + immediate into a 32-bit word and queues it in a small FIFO.
// Optional immediate range checking is enabled with the INSTR_ENC_RANGE_CHECK_EN macro.
module instruction_encoder #(
  parameter int OUT_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_fmt,
  input  logic [6:0]                   in_opcode,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [2:0]                   in_funct3,
  input  logic [6:0]                   in_funct7,
  input  logic [31:0]                  in_imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic                         out_err,
  output logic [$clog2(OUT_DEPTH):0]   out_level
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(OUT_DEPTH);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0]   instr_mem [OUT_DEPTH];
  logic          err_mem   [OUT_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          alive_reg;

  logic [31:0]   enc_word;
  logic          fmt_err;
  logic          range_err;
  logic          push;
  logic          pop;

  // Field packing; reserved formats collapse to a NOP flagged as an error.
  always_comb begin
    enc_word = NOP_WORD;
    fmt_err  = 1'b0;
    case (in_fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: begin
        enc_word = NOP_WORD;
        fmt_err  = 1'b1;
      end
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // An immediate fits N signed bits when every bit from N-1 upward equals the sign.
  logic sext12;
  logic sext13;
  logic sext21;

  assign sext12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sext13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign sext21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    range_err = 1'b0;
    case (in_fmt)
      FMT_I, FMT_S: range_err = ~sext12;
      FMT_B:        range_err = ~sext13 | in_imm[0];
      FMT_J:        range_err = ~sext21 | in_imm[0];
      FMT_U:        range_err = |in_imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  // alive_reg holds off acceptance until the first edge after reset release.
  assign in_ready  = alive_reg && (level_reg < DEPTH_L);
  assign out_valid = (level_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : 32'h0;
  assign out_err   = out_valid ? err_mem[rd_ptr_reg]   : 1'b0;
  assign out_level = level_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= enc_word;
      err_mem[wr_ptr_reg]   <= fmt_err | range_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      alive_reg  <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule
